// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default constants for the 2-read/1-write register file.
//   DATA_W_DEF : default register width in bits
//   NREGS_DEF  : default number of registers
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int NREGS_DEF  = 8;

endpackage

// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if: write port, two read ports and written mask of the
// register file, bundled as one bus.
//   slave  : register file side (drives read data, valid strobes, mask)
//   master : requester side (drives write and read requests)
interface regfile_2r1w_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS)
);

   logic              write;
   logic [ADDR_W-1:0] writenum;
   logic [DATA_W-1:0] data_in;
   logic              rd_en_a;
   logic [ADDR_W-1:0] readnum_a;
   logic              rd_en_b;
   logic [ADDR_W-1:0] readnum_b;
   logic [DATA_W-1:0] data_out_a;
   logic [DATA_W-1:0] data_out_b;
   logic              rd_valid_a;
   logic              rd_valid_b;
   logic [NREGS-1:0]  written_mask;

   modport slave (
      input  write, writenum, data_in,
      input  rd_en_a, readnum_a, rd_en_b, readnum_b,
      output data_out_a, data_out_b, rd_valid_a, rd_valid_b, written_mask
   );

   modport master (
      output write, writenum, data_in,
      output rd_en_a, readnum_a, rd_en_b, readnum_b,
      input  data_out_a, data_out_b, rd_valid_a, rd_valid_b, written_mask
   );

endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port of the register file.
//   clk, reset   : clock, synchronous active-high reset
//   regs_i       : whole storage array (pre-write contents)
//   wr_en_i      : qualified write (in range, not a hard-wired zero reg)
//   wr_num_i     : write index
//   wr_data_i    : write data, used for write-first bypass
//   rd_en_i      : read request
//   rd_num_i     : read index
//   rd_data_o    : read data
//   rd_valid_o   : read data valid
module regfile_rdport #(
   parameter int DATA_W   = 16,
   parameter int NREGS    = 8,
   parameter int ADDR_W   = $clog2(NREGS),
   parameter int READ_REG = 1,
   parameter int R0_ZERO  = 0
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NREGS-1:0][DATA_W-1:0]   regs_i,
   input  logic                           wr_en_i,
   input  logic [ADDR_W-1:0]              wr_num_i,
   input  logic [DATA_W-1:0]              wr_data_i,
   input  logic                           rd_en_i,
   input  logic [ADDR_W-1:0]              rd_num_i,
   output logic [DATA_W-1:0]              rd_data_o,
   output logic                           rd_valid_o
);

   logic              masked;
   logic [DATA_W-1:0] stored;
   logic [DATA_W-1:0] rd_raw;
   logic [DATA_W-1:0] rd_byp;

   // Out-of-range and hard-wired zero indices read as 0 and override the
   // bypass; NREGS need not be a power of two, so the range test is real.
   assign masked = (int'(rd_num_i) >= NREGS) || ((R0_ZERO != 0) && (rd_num_i == '0));

   // Decoded mux keeps the select inside the array bounds.
   always_comb begin
      stored = '0;
      for (int i = 0; i < NREGS; i++)
         if (rd_num_i == ADDR_W'(i)) stored = regs_i[i];
   end

   assign rd_raw = masked ? '0 : stored;
   assign rd_byp = (!masked && wr_en_i && (wr_num_i == rd_num_i)) ? wr_data_i : rd_raw;

   generate
      if (READ_REG != 0) begin : g_reg
         logic [DATA_W-1:0] data_q;
         logic              valid_q;

         // Data holds when no read is requested; valid drops.
         always_ff @(posedge clk) begin
            if (reset) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_en_i;
               if (rd_en_i) data_q <= rd_byp;
            end
         end

         assign rd_data_o  = data_q;
         assign rd_valid_o = valid_q;
      end else begin : g_comb
         // Combinational port: no state, no bypass (shows pre-write value).
         logic unused_ok;
         assign unused_ok  = ^{clk, reset, rd_byp};
         assign rd_data_o  = rd_raw;
         assign rd_valid_o = rd_en_i;
      end
   endgenerate

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x DATA_W register file, one write port, two
// independent read ports (A, B), per-register written mask.
//   clk, reset : clock, synchronous active-high reset (wins over a write)
//   bus        : regfile_2r1w_if slave - write request, read requests A/B,
//                read data/valid A/B, written_mask
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ADDR_W   = $clog2(NREGS),
   parameter int READ_REG = 1,
   parameter int R0_ZERO  = 0
)(
   input  logic           clk,
   input  logic           reset,
   regfile_2r1w_if.slave  bus
);

   logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NREGS-1:0]             mask_q, mask_d;
   logic                         wr_ok;

   // A write only lands on an existing, writable register.
   assign wr_ok = bus.write
                  && (int'(bus.writenum) < NREGS)
                  && !((R0_ZERO != 0) && (bus.writenum == '0));

   always_comb begin
      regs_d = regs_q;
      mask_d = mask_q;
      for (int i = 0; i < NREGS; i++) begin
         if (wr_ok && (bus.writenum == ADDR_W'(i))) begin
            regs_d[i] = bus.data_in;
            mask_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
         mask_q <= '0;
      end else begin
         regs_q <= regs_d;
         mask_q <= mask_d;
      end
   end

   assign bus.written_mask = mask_q;

   regfile_rdport #(
      .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
      .READ_REG(READ_REG), .R0_ZERO(R0_ZERO)
   ) u_rd_a (
      .clk        (clk),
      .reset      (reset),
      .regs_i     (regs_q),
      .wr_en_i    (wr_ok),
      .wr_num_i   (bus.writenum),
      .wr_data_i  (bus.data_in),
      .rd_en_i    (bus.rd_en_a),
      .rd_num_i   (bus.readnum_a),
      .rd_data_o  (bus.data_out_a),
      .rd_valid_o (bus.rd_valid_a)
   );

   regfile_rdport #(
      .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
      .READ_REG(READ_REG), .R0_ZERO(R0_ZERO)
   ) u_rd_b (
      .clk        (clk),
      .reset      (reset),
      .regs_i     (regs_q),
      .wr_en_i    (wr_ok),
      .wr_num_i   (bus.writenum),
      .wr_data_i  (bus.data_in),
      .rd_en_i    (bus.rd_en_b),
      .rd_num_i   (bus.readnum_b),
      .rd_data_o  (bus.data_out_b),
      .rd_valid_o (bus.rd_valid_b)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: three register file configurations driven by the same
// stimulus and compared against a behavioural array model.
//   cfg 0 : NREGS=8, registered reads, no zero register
//   cfg 1 : NREGS=6, combinational reads, R0 hard-wired zero
//   cfg 2 : NREGS=6, registered reads, R0 hard-wired zero
module tb_regfile_2r1w;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, write, rd_en_a, rd_en_b;
   logic [2:0]  writenum, readnum_a, readnum_b;
   logic [15:0] data_in;

   regfile_2r1w_if #(.DATA_W(16), .NREGS(8)) if0 ();
   regfile_2r1w_if #(.DATA_W(16), .NREGS(6)) if1 ();
   regfile_2r1w_if #(.DATA_W(16), .NREGS(6)) if2 ();

   assign {if0.write, if0.writenum, if0.data_in, if0.rd_en_a, if0.readnum_a, if0.rd_en_b, if0.readnum_b}
        = {write, writenum, data_in, rd_en_a, readnum_a, rd_en_b, readnum_b};
   assign {if1.write, if1.writenum, if1.data_in, if1.rd_en_a, if1.readnum_a, if1.rd_en_b, if1.readnum_b}
        = {write, writenum, data_in, rd_en_a, readnum_a, rd_en_b, readnum_b};
   assign {if2.write, if2.writenum, if2.data_in, if2.rd_en_a, if2.readnum_a, if2.rd_en_b, if2.readnum_b}
        = {write, writenum, data_in, rd_en_a, readnum_a, rd_en_b, readnum_b};

   regfile_2r1w #(.DATA_W(16), .NREGS(8), .READ_REG(1), .R0_ZERO(0))
      u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   regfile_2r1w #(.DATA_W(16), .NREGS(6), .READ_REG(0), .R0_ZERO(1))
      u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
   regfile_2r1w #(.DATA_W(16), .NREGS(6), .READ_REG(1), .R0_ZERO(1))
      u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

   logic [15:0] dout_a [3];
   logic [15:0] dout_b [3];
   logic        vld_a  [3];
   logic        vld_b  [3];
   logic [7:0]  mask_o [3];

   assign dout_a[0] = if0.data_out_a;  assign dout_b[0] = if0.data_out_b;
   assign dout_a[1] = if1.data_out_a;  assign dout_b[1] = if1.data_out_b;
   assign dout_a[2] = if2.data_out_a;  assign dout_b[2] = if2.data_out_b;
   assign vld_a[0]  = if0.rd_valid_a;  assign vld_b[0]  = if0.rd_valid_b;
   assign vld_a[1]  = if1.rd_valid_a;  assign vld_b[1]  = if1.rd_valid_b;
   assign vld_a[2]  = if2.rd_valid_a;  assign vld_b[2]  = if2.rd_valid_b;
   assign mask_o[0] = if0.written_mask;
   assign mask_o[1] = {2'b00, if1.written_mask};
   assign mask_o[2] = {2'b00, if2.written_mask};

   // Reference model state
   int          nr [3] = '{8, 6, 6};
   bit          r0 [3] = '{1'b0, 1'b1, 1'b1};
   logic [15:0] mem [3][8];
   logic [7:0]  mmask [3];
   logic [15:0] ex_a [3];
   logic [15:0] ex_b [3];
   logic        ex_va [3];
   logic        ex_vb [3];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Value a read of idx returns; byp selects write-first visibility.
   function automatic logic [15:0] mrd(int c, logic [2:0] idx, bit byp);
      if (int'(idx) >= nr[c] || (r0[c] && idx == 3'd0)) return 16'h0000;
      if (byp && write && !reset && writenum == idx) return data_in;
      return mem[c][idx];
   endfunction

   function automatic void mwr(int c);
      if (reset) begin
         for (int i = 0; i < 8; i++) mem[c][i] = 16'h0000;
         mmask[c] = 8'h00;
      end else if (write && int'(writenum) < nr[c] && !(r0[c] && writenum == 3'd0)) begin
         mem[c][writenum]   = data_in;
         mmask[c][writenum] = 1'b1;
      end
   endfunction

   // One clock cycle: drive, check combinational port, advance model,
   // check registered ports and masks after the edge.
   task automatic cyc(input logic w, input logic [2:0] wn, input logic [15:0] din,
                      input logic ea, input logic [2:0] na,
                      input logic eb, input logic [2:0] nb, input logic rs);
      @(negedge clk);
      write = w; writenum = wn; data_in = din;
      rd_en_a = ea; readnum_a = na; rd_en_b = eb; readnum_b = nb; reset = rs;
      #1;
      chk("c1_comb_dout_a", dout_a[1], mrd(1, na, 1'b0));
      chk("c1_comb_dout_b", dout_b[1], mrd(1, nb, 1'b0));
      chk("c1_comb_vld_a", vld_a[1], ea);
      chk("c1_comb_vld_b", vld_b[1], eb);
      for (int c = 0; c < 3; c += 2) begin
         if (rs) begin
            ex_a[c] = 16'h0; ex_b[c] = 16'h0; ex_va[c] = 1'b0; ex_vb[c] = 1'b0;
         end else begin
            ex_va[c] = ea; ex_vb[c] = eb;
            if (ea) ex_a[c] = mrd(c, na, 1'b1);
            if (eb) ex_b[c] = mrd(c, nb, 1'b1);
         end
      end
      for (int c = 0; c < 3; c++) mwr(c);
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c += 2) begin
         chk($sformatf("c%0d_dout_a", c), dout_a[c], ex_a[c]);
         chk($sformatf("c%0d_dout_b", c), dout_b[c], ex_b[c]);
         chk($sformatf("c%0d_vld_a", c), vld_a[c], ex_va[c]);
         chk($sformatf("c%0d_vld_b", c), vld_b[c], ex_vb[c]);
      end
      for (int c = 0; c < 3; c++) chk($sformatf("c%0d_mask", c), mask_o[c], mmask[c]);
   endtask

   initial begin
      reset = 1'b1; write = 1'b0; writenum = 3'd0; data_in = 16'h0;
      rd_en_a = 1'b0; readnum_a = 3'd0; rd_en_b = 1'b0; readnum_b = 3'd0;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         mwr(c);
         ex_a[c] = 16'h0; ex_b[c] = 16'h0; ex_va[c] = 1'b0; ex_vb[c] = 1'b0;
      end
      #1;
      chk("rst_dout_a0", dout_a[0], 16'h0000);
      chk("rst_vld_a0", vld_a[0], 1'b0);
      chk("rst_vld_b2", vld_b[2], 1'b0);
      chk("rst_mask0", mask_o[0], 8'h00);
      chk("rst_mask2", mask_o[2], 8'h00);

      // Read every register on both ports after reset.
      for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0);

      // Write R3, read it on both ports next cycle.
      cyc(1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
      chk("r3_dout_a0", dout_a[0], 16'hABCD);
      chk("r3_dout_b0", dout_b[0], 16'hABCD);
      chk("r3_mask0", mask_o[0], 8'h08);

      // Write-first bypass on R5 (old value 0x0001).
      cyc(1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      cyc(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
      chk("byp_dout_a0", dout_a[0], 16'h1234);
      chk("byp_dout_a2", dout_a[2], 16'h1234);

      // Hard-wired zero register, including bypass attempt.
      cyc(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("r0_byp_dout_a2", dout_a[2], 16'h0000);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("r0_dout_a2", dout_a[2], 16'h0000);
      chk("r0_dout_a0", dout_a[0], 16'hFFFF);
      chk("r0_mask2", mask_o[2], 8'h28);

      // Out-of-range index on the 6-entry files.
      cyc(1'b1, 3'd7, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b1, 3'd6, 1'b0);
      chk("oor_dout_a2", dout_a[2], 16'h0000);
      chk("oor_vld_a2", vld_a[2], 1'b1);
      chk("oor_vld_b2", vld_b[2], 1'b1);
      chk("oor_mask2", mask_o[2], 8'h28);
      chk("oor_mask0", mask_o[0], 8'hA9);
      chk("oor_dout_a0", dout_a[0], 16'h5555);

      // Write and read during reset: reset wins, then R2 reads zero.
      cyc(1'b1, 3'd2, 16'h00FF, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1);
      chk("rstw_vld_a0", vld_a[0], 1'b0);
      chk("rstw_dout_a0", dout_a[0], 16'h0000);
      chk("rstw_mask0", mask_o[0], 8'h00);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0);
      chk("rstw_rd_a0", dout_a[0], 16'h0000);
      chk("rstw_rd_vld_a0", vld_a[0], 1'b1);

      // Randomised traffic with occasional reset.
      for (int n = 0; n < 400; n++)
         cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 39) == 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised successor to the single-port register file of the 5-stage RISC datapath. Provides NREGS registers of DATA_W bits with one write port and two independent read ports (A, B), so both ALU operands are fetched in the same cycle. Read ports are registered with a valid strobe and write-first bypass. The block adds synchronous clear, an optional hard-wired zero register, and a per-register written mask for the decode-stage hazard logic.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers (2..32; need not be a power of two)
- ADDR_W, $clog2(NREGS), register index width
- READ_REG, 1, 1 = registered reads (latency 1); 0 = combinational reads
- R0_ZERO, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- write  in  1  write enable
- writenum  in  ADDR_W  write register index
- data_in  in  DATA_W  write data
- rd_en_a / rd_en_b  in  1  read request, port A / B
- readnum_a / readnum_b  in  ADDR_W  read register index, port A / B
- data_out_a / data_out_b  out  DATA_W  read data, port A / B
- rd_valid_a / rd_valid_b  out  1  read data valid, port A / B
- written_mask  out  NREGS  bit i = 1 if register i has been written since reset

## Operation
- Reset (reset = 1 at a clock edge):
  - All registers, data_out_a/b and written_mask clear to 0; rd_valid_a/b clear to 0.
  - A write or read presented in the same cycle is ignored.
- Write: when write = 1 and writenum < NREGS, data_in is stored in register writenum at the edge, and written_mask[writenum] sets. Every other register holds its value.
- Out-of-range index (>= NREGS):
  - Writes are dropped; written_mask is unchanged.
  - Reads return 0 and still assert rd_valid.
- R0_ZERO = 1:
  - Writes to index 0 are dropped; written_mask[0] stays 0.
  - Reads of index 0 return 0.
- Read ports are fully independent. A and B may address the same register, or the register being written, in the same cycle.
- READ_REG = 1:
  - rd_en_x = 1 in cycle n gives data_out_x and rd_valid_x = 1 in cycle n+1.
  - rd_en_x = 0 gives rd_valid_x = 0 next cycle, and data_out_x holds its last value.
  - Write-first bypass: if write = 1 and writenum == readnum_x in cycle n, data_out_x in n+1 equals data_in. R0_ZERO and out-of-range rules take priority over the bypass.
- READ_REG = 0:
  - data_out_x is combinational from readnum_x and shows the stored (pre-write) value.
  - rd_valid_x = rd_en_x combinationally.
  - No bypass in this mode.

## Timing
- Write-to-read latency: 0 extra cycles with READ_REG = 1 (bypass); 1 cycle with READ_REG = 0.
- Read latency: 1 cycle (READ_REG = 1) or 0 (READ_REG = 0).
- written_mask is registered and updates at the same edge as the write.
- Back-to-back reads on every cycle are supported with no bubbles.
- Reset mid-stream:
  - A read issued in the reset cycle produces rd_valid = 0 next cycle.
  - A read issued the cycle before reset has its result overwritten by the reset values (data 0, valid 0).
- Simultaneous write and reset: reset wins.

## Structure
- Package regfile_pkg holds the default constants: DATA_W_DEF = 16 and NREGS_DEF = 8.
- Sub-module regfile_rdport is instantiated once per read port. It contains the index compare, bypass mux, zero/range masking and the output register, and is parametrised by DATA_W, NREGS, ADDR_W, READ_REG and R0_ZERO.
- The top level owns the storage array, write decode and written_mask.

## Test plan
- Reset then read all 8 registers on A and B (default parameters) -> data_out = 0x0000, rd_valid = 1 one cycle after each rd_en; written_mask = 8'h00.
- Write 0xABCD to R3; next cycle read A = 3, B = 3 -> both ports give 0xABCD after 1 cycle; written_mask = 8'h08.
- Same cycle: write 0x1234 to R5 while rd_en_a = 1, readnum_a = 5 (R5 previously 0x0001) -> READ_REG = 1: data_out_a = 0x1234 next cycle; READ_REG = 0: data_out_a = 0x0001 in that cycle.
- R0_ZERO = 1: write 0xFFFF to R0, then read 0 -> data_out = 0x0000; written_mask[0] = 0.
- NREGS = 6: write 0x5555 to index 7, then read index 7 -> write dropped, data_out = 0, rd_valid = 1, written_mask unchanged.
- Write R2 = 0x00FF with reset = 1 in the same cycle, then read R2 -> 0x0000; rd_valid = 0 in the cycle after the reset cycle.
